// File: rtl/cpc_bank_pkg.sv
// Shared definitions for the CPC RAM banking controller: mode codes,
// capture FSM states, config-port decode constants and the page mapper.
package cpc_bank_pkg;

    localparam logic [2:0] MODE_0 = 3'd0;
    localparam logic [2:0] MODE_1 = 3'd1;
    localparam logic [2:0] MODE_2 = 3'd2;
    localparam logic [2:0] MODE_3 = 3'd3;
    localparam logic [2:0] MODE_4 = 3'd4;
    localparam logic [2:0] MODE_5 = 3'd5;
    localparam logic [2:0] MODE_6 = 3'd6;
    localparam logic [2:0] MODE_7 = 3'd7;

    // Config port decodes on A15 low with data tag D7:6 = 11
    localparam logic       CFG_PORT_A15 = 1'b0;
    localparam logic [1:0] CFG_TAG      = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } cap_state_t;

    // Returns {hit, subpage} for a 16K CPU page under a given mode
    function automatic logic [2:0] page_map(input logic [2:0] mode, input logic [1:0] p);
        logic       hit;
        logic [1:0] sub;
        hit = 1'b0;
        sub = 2'd0;
        case (mode)
            MODE_0: begin
                hit = 1'b0;
                sub = 2'd0;
            end
            MODE_1, MODE_3: begin
                // Mode 3 leaves page 1 on internal RAM, so only page 3 maps
                hit = (p == 2'd3);
                sub = 2'd3;
            end
            MODE_2: begin
                hit = 1'b1;
                sub = p;
            end
            MODE_4, MODE_5, MODE_6, MODE_7: begin
                hit = (p == 2'd1);
                sub = mode[1:0];
            end
            default: begin
                hit = 1'b0;
                sub = 2'd0;
            end
        endcase
        return {hit, sub};
    endfunction

endpackage

// File: rtl/cpc_iowr_capture.sv
// Glitch-filtered capture of config-port I/O writes.
// Ports:
//   i_clk, i_rst_n    bus clock, async active-low reset
//   i_ioreq_b, i_wr_b Z80 strobes
//   i_a15             address bit 15
//   i_tag             data bits 7:6
//   o_load_c          combinational load strobe, high during the cycle whose
//                     rising edge is the FILTER-th consecutive write sample
module cpc_iowr_capture
    import cpc_bank_pkg::*;
#(
    parameter int unsigned FILTER = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ioreq_b,
    input  logic       i_wr_b,
    input  logic       i_a15,
    input  logic [1:0] i_tag,
    output logic       o_load_c
);

    localparam int unsigned CNT_W = 2;

    cap_state_t         r_state;
    logic [CNT_W-1:0]   r_count;
    logic               w_cfg_wr;
    logic               w_count_full;

    assign w_cfg_wr     = ~i_ioreq_b & ~i_wr_b & (i_a15 == CFG_PORT_A15) & (i_tag == CFG_TAG);
    assign w_count_full = (r_count == CNT_W'(FILTER - 1));

    // Load fires on the edge that completes the run, so cfg updates on that same edge
    assign o_load_c = (r_state == IDLE) & w_cfg_wr & w_count_full;

    // Filter counter and IDLE/HOLD sequencing; HOLD blocks reloads until the cycle ends
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (o_load_c) begin
                        r_state <= HOLD;
                        r_count <= '0;
                    end else if (w_cfg_wr) begin
                        r_count <= r_count + CNT_W'(1);
                    end else begin
                        r_count <= '0;
                    end
                end
                HOLD: begin
                    r_count <= '0;
                    if (i_ioreq_b | i_wr_b) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cpc_bank_ctrl.sv
// CPC RAM expansion banking controller: holds the 6128-style config
// register and maps CPU pages onto expansion SRAM blocks.
// Ports:
//   CLK, RESET_B      bus clock, async active-low reset
//   A, D              CPU address and data buses
//   IOREQ_B, MREQ_B, RFSH_B, WR_B  Z80 strobes
//   dip_en            expansion enable (0 forces mode 0)
//   dip_ext           honour address-derived extra block bits
//   HIADR             SRAM high address {block, subpage}
//   RAMCS_B, RAMWE_B  SRAM chip-select / write-enable, active low
//   RAMDIS            internal RAM disable, active high
module cpc_bank_ctrl
    import cpc_bank_pkg::*;
#(
    parameter  int unsigned BLK_BITS  = 3,
    parameter  int unsigned EXT_BITS  = 0,
    parameter  int unsigned FILTER    = 2,
    localparam int unsigned NBLK      = BLK_BITS + EXT_BITS,
    localparam int unsigned PAGE_BITS = NBLK + 2
) (
    input  logic                 CLK,
    input  logic                 RESET_B,
    input  logic [15:0]          A,
    input  logic [7:0]           D,
    input  logic                 IOREQ_B,
    input  logic                 MREQ_B,
    input  logic                 RFSH_B,
    input  logic                 WR_B,
    input  logic                 dip_en,
    input  logic                 dip_ext,
    output logic [PAGE_BITS-1:0] HIADR,
    output logic                 RAMCS_B,
    output logic                 RAMWE_B,
    output logic                 RAMDIS
);

    logic [NBLK-1:0] r_cfg_blk;
    logic [2:0]      r_cfg_mode;
    logic [NBLK-1:0] w_new_blk;
    logic            w_load;
    logic [2:0]      w_eff_mode;
    logic [2:0]      w_map;
    logic            w_hit;
    logic [1:0]      w_sub;
    logic            w_sel;
    logic            w_unused;

    // Address bits only partly used depending on EXT_BITS
    assign w_unused = ^A[13:0];

    cpc_iowr_capture #(
        .FILTER (FILTER)
    ) u_capture (
        .i_clk     (CLK),
        .i_rst_n   (RESET_B),
        .i_ioreq_b (IOREQ_B),
        .i_wr_b    (WR_B),
        .i_a15     (A[15]),
        .i_tag     (D[7:6]),
        .o_load_c  (w_load)
    );

    // Extra block bits come from inverted A5:3 upward, zeroed when dip_ext is off
    if (EXT_BITS > 0) begin : g_ext
        assign w_new_blk = {~A[3 +: EXT_BITS] & {EXT_BITS{dip_ext}}, D[3 +: BLK_BITS]};
    end else begin : g_noext
        assign w_new_blk = D[3 +: BLK_BITS];
    end

    // Config register
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_cfg_blk  <= '0;
            r_cfg_mode <= MODE_0;
        end else if (w_load) begin
            r_cfg_blk  <= w_new_blk;
            r_cfg_mode <= D[2:0];
        end
    end

    // Combinational mapping; reset cfg is mode 0, so outputs idle during reset
    assign w_eff_mode = dip_en ? r_cfg_mode : MODE_0;
    assign w_map      = page_map(w_eff_mode, A[15:14]);
    assign w_hit      = w_map[2];
    assign w_sub      = w_map[1:0];
    assign w_sel      = ~MREQ_B & RFSH_B & w_hit;

    assign RAMCS_B = ~w_sel;
    assign RAMDIS  = w_sel;
    assign RAMWE_B = ~(w_sel & ~WR_B);
    assign HIADR   = w_hit ? {r_cfg_blk, w_sub} : '0;

endmodule
